outcode_pipe: RTL and testbench

- Streaming, parametrised successor to the combinational point outcode logic.
- Accepts line segments (two endpoints) on a valid/ready interface and computes the 4-bit Cohen-Sutherland outcode of each endpoint against a runtime-programmable clip window.
- Classifies each segment as trivial-accept, trivial-reject or needs-clip, and keeps saturating per-class statistics counters.
- Sits between the vertex transform stage and the line clipper/rasteriser.

---
 rtl/outcode_pipe_if.sv | 41 ++++
 rtl/outcode_pipe.sv | 131 +++++++++++++
 tb/tb_outcode_pipe.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/outcode_pipe_if.sv
// Segment stream, window configuration and statistics bundle for outcode_pipe.
// The slave modport is the pipe's view; the master modport is the producer/consumer side.
interface outcode_pipe_if #(
  parameter int COORD_W = 16,
  parameter int CNT_W   = 16
);
  logic                      cfg_we;
  logic signed [COORD_W-1:0] cfg_xmin, cfg_xmax, cfg_ymin, cfg_ymax;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [COORD_W-1:0] in_x0, in_y0, in_x1, in_y1;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [COORD_W-1:0] out_x0, out_y0, out_x1, out_y1;
  logic [3:0]                out_code0, out_code1;
  logic                      out_accept, out_reject;
  logic                      cnt_clr;
  logic [CNT_W-1:0]          cnt_accept, cnt_reject, cnt_clip;

  modport slave (
    input  cfg_we, cfg_xmin, cfg_xmax, cfg_ymin, cfg_ymax,
    input  in_valid, in_x0, in_y0, in_x1, in_y1,
    output in_ready,
    output out_valid, out_x0, out_y0, out_x1, out_y1,
    output out_code0, out_code1, out_accept, out_reject,
    input  out_ready,
    input  cnt_clr,
    output cnt_accept, cnt_reject, cnt_clip
  );

  modport master (
    output cfg_we, cfg_xmin, cfg_xmax, cfg_ymin, cfg_ymax,
    output in_valid, in_x0, in_y0, in_x1, in_y1,
    input  in_ready,
    input  out_valid, out_x0, out_y0, out_x1, out_y1,
    input  out_code0, out_code1, out_accept, out_reject,
    output out_ready,
    output cnt_clr,
    input  cnt_accept, cnt_reject, cnt_clip
  );
endinterface

// File: rtl/outcode_pipe.sv
// Two-stage streaming Cohen-Sutherland outcode/classification pipe with a
// programmable clip window and saturating per-class segment counters.
module outcode_pipe #(
  parameter int COORD_W  = 16,
  parameter int XMIN_RST = 0,
  parameter int XMAX_RST = 640,
  parameter int YMIN_RST = 0,
  parameter int YMAX_RST = 480,
  parameter int CNT_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  outcode_pipe_if.slave  bus
);
  typedef logic signed [COORD_W-1:0] coord_t;

  coord_t r_xmin, r_xmax, r_ymin, r_ymax;

  logic       r_s1_valid;
  coord_t     r_s1_x0, r_s1_y0, r_s1_x1, r_s1_y1;
  logic [3:0] r_s1_c0, r_s1_c1;

  logic       r_s2_valid;
  coord_t     r_s2_x0, r_s2_y0, r_s2_x1, r_s2_y1;
  logic [3:0] r_s2_c0, r_s2_c1;
  logic       r_s2_acc, r_s2_rej;

  logic [CNT_W-1:0] r_cnt_acc, r_cnt_rej, r_cnt_clip;

  logic       w_s2_adv, w_s1_adv, w_in_hs, w_out_hs;
  logic [3:0] w_c0, w_c1;

  // LEFT/RIGHT and BOTTOM/TOP are exclusive per axis, even for an inverted window
  function automatic logic [3:0] f_code(input coord_t x, input coord_t y,
                                        input coord_t xmin, input coord_t xmax,
                                        input coord_t ymin, input coord_t ymax);
    logic [3:0] c;
    c = 4'b0000;
    if (x < xmin)      c[0] = 1'b1;
    else if (x > xmax) c[1] = 1'b1;
    if (y < ymin)      c[2] = 1'b1;
    else if (y > ymax) c[3] = 1'b1;
    return c;
  endfunction

  assign w_c0 = f_code(bus.in_x0, bus.in_y0, r_xmin, r_xmax, r_ymin, r_ymax);
  assign w_c1 = f_code(bus.in_x1, bus.in_y1, r_xmin, r_xmax, r_ymin, r_ymax);

  assign w_s2_adv = !r_s2_valid || bus.out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_in_hs  = bus.in_valid && w_s1_adv;
  assign w_out_hs = r_s2_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xmin <= coord_t'(XMIN_RST);
      r_xmax <= coord_t'(XMAX_RST);
      r_ymin <= coord_t'(YMIN_RST);
      r_ymax <= coord_t'(YMAX_RST);
    end else if (bus.cfg_we) begin
      r_xmin <= bus.cfg_xmin;
      r_xmax <= bus.cfg_xmax;
      r_ymin <= bus.cfg_ymin;
      r_ymax <= bus.cfg_ymax;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_x0 <= '0; r_s1_y0 <= '0; r_s1_x1 <= '0; r_s1_y1 <= '0;
      r_s1_c0 <= '0; r_s1_c1 <= '0;
    end else begin
      if (w_s1_adv) r_s1_valid <= bus.in_valid;
      if (w_in_hs) begin
        r_s1_x0 <= bus.in_x0; r_s1_y0 <= bus.in_y0;
        r_s1_x1 <= bus.in_x1; r_s1_y1 <= bus.in_y1;
        r_s1_c0 <= w_c0;      r_s1_c1 <= w_c1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_x0 <= '0; r_s2_y0 <= '0; r_s2_x1 <= '0; r_s2_y1 <= '0;
      r_s2_c0 <= '0; r_s2_c1 <= '0;
      r_s2_acc <= 1'b0; r_s2_rej <= 1'b0;
    end else begin
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
      if (w_s2_adv && r_s1_valid) begin
        r_s2_x0  <= r_s1_x0; r_s2_y0 <= r_s1_y0;
        r_s2_x1  <= r_s1_x1; r_s2_y1 <= r_s1_y1;
        r_s2_c0  <= r_s1_c0; r_s2_c1 <= r_s1_c1;
        r_s2_acc <= ((r_s1_c0 | r_s1_c1) == 4'b0000);
        r_s2_rej <= ((r_s1_c0 & r_s1_c1) != 4'b0000);
      end
    end
  end

  // Clear wins over a same-cycle increment; counters stick at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_acc <= '0; r_cnt_rej <= '0; r_cnt_clip <= '0;
    end else if (bus.cnt_clr) begin
      r_cnt_acc <= '0; r_cnt_rej <= '0; r_cnt_clip <= '0;
    end else if (w_out_hs) begin
      if (r_s2_acc) begin
        if (!(&r_cnt_acc)) r_cnt_acc <= r_cnt_acc + 1'b1;
      end else if (r_s2_rej) begin
        if (!(&r_cnt_rej)) r_cnt_rej <= r_cnt_rej + 1'b1;
      end else begin
        if (!(&r_cnt_clip)) r_cnt_clip <= r_cnt_clip + 1'b1;
      end
    end
  end

  assign bus.in_ready   = w_s1_adv;
  assign bus.out_valid  = r_s2_valid;
  assign bus.out_x0     = r_s2_x0;
  assign bus.out_y0     = r_s2_y0;
  assign bus.out_x1     = r_s2_x1;
  assign bus.out_y1     = r_s2_y1;
  assign bus.out_code0  = r_s2_c0;
  assign bus.out_code1  = r_s2_c1;
  assign bus.out_accept = r_s2_acc;
  assign bus.out_reject = r_s2_rej;
  assign bus.cnt_accept = r_cnt_acc;
  assign bus.cnt_reject = r_cnt_rej;
  assign bus.cnt_clip   = r_cnt_clip;
endmodule

// File: tb/tb_outcode_pipe.sv
// Scoreboard bench for outcode_pipe: a reference model predicts each segment's
// result at input handshake; a monitor checks outputs, stalls and counters.
module tb_outcode_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  outcode_pipe_if #(.COORD_W(16), .CNT_W(16)) b1 ();
  outcode_pipe_if #(.COORD_W(16), .CNT_W(2))  b2 ();

  outcode_pipe #(.COORD_W(16), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(b1));
  outcode_pipe #(.COORD_W(16), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(b2));

  // Narrow-counter instance sees exactly the same traffic
  assign b2.cfg_we = b1.cfg_we;
  assign b2.cfg_xmin = b1.cfg_xmin;
  assign b2.cfg_xmax = b1.cfg_xmax;
  assign b2.cfg_ymin = b1.cfg_ymin;
  assign b2.cfg_ymax = b1.cfg_ymax;
  assign b2.in_valid = b1.in_valid;
  assign b2.in_x0 = b1.in_x0;
  assign b2.in_y0 = b1.in_y0;
  assign b2.in_x1 = b1.in_x1;
  assign b2.in_y1 = b1.in_y1;
  assign b2.out_ready = b1.out_ready;
  assign b2.cnt_clr = b1.cnt_clr;

  typedef struct {
    logic [15:0] x0, y0, x1, y1;
    logic [3:0]  c0, c1;
    logic        acc, rej;
  } exp_t;

  exp_t exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  int wxmin = 0, wxmax = 640, wymin = 0, wymax = 480;
  int m_acc = 0, m_rej = 0, m_clip = 0;
  int m2_acc = 0, m2_rej = 0, m2_clip = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  function automatic logic [3:0] oc(input int x, input int y);
    logic [3:0] c;
    c = 4'b0000;
    if (x < wxmin) c = c | 4'b0001;
    else if (x > wxmax) c = c | 4'b0010;
    if (y < wymin) c = c | 4'b0100;
    else if (y > wymax) c = c | 4'b1000;
    return c;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // Monitor / scoreboard
  logic stall_prev = 1'b0;
  logic [101:0] snap;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        chk("cnt_accept", 64'(b1.cnt_accept), 64'(m_acc));
        chk("cnt_reject", 64'(b1.cnt_reject), 64'(m_rej));
        chk("cnt_clip",   64'(b1.cnt_clip),   64'(m_clip));
        chk("cnt2_accept", 64'(b2.cnt_accept), 64'(m2_acc));
        chk("cnt2_reject", 64'(b2.cnt_reject), 64'(m2_rej));
        chk("cnt2_clip",   64'(b2.cnt_clip),   64'(m2_clip));
        if (stall_prev)
          chk("stall_hold", 64'({b1.out_valid, b1.out_x0, b1.out_y0, b1.out_x1, b1.out_y1,
                                 b1.out_code0, b1.out_code1, b1.out_accept, b1.out_reject} ^ snap[101:0]),
              64'(0));
        if (b1.out_valid && b1.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 64'(1), 64'(0));
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_coords", {b1.out_x0, b1.out_y0, b1.out_x1, b1.out_y1}, {e.x0, e.y0, e.x1, e.y1});
            chk("out_codes", 64'({b1.out_code0, b1.out_code1}), 64'({e.c0, e.c1}));
            chk("out_class", 64'({b1.out_accept, b1.out_reject}), 64'({e.acc, e.rej}));
            if (!b1.cnt_clr) begin
              if (e.acc) begin m_acc = sat(m_acc, 65535); m2_acc = sat(m2_acc, 3); end
              else if (e.rej) begin m_rej = sat(m_rej, 65535); m2_rej = sat(m2_rej, 3); end
              else begin m_clip = sat(m_clip, 65535); m2_clip = sat(m2_clip, 3); end
            end
          end
        end
        if (b1.cnt_clr) begin
          m_acc = 0; m_rej = 0; m_clip = 0; m2_acc = 0; m2_rej = 0; m2_clip = 0;
        end
        stall_prev = b1.out_valid && !b1.out_ready;
        snap = {b1.out_valid, b1.out_x0, b1.out_y0, b1.out_x1, b1.out_y1,
                b1.out_code0, b1.out_code1, b1.out_accept, b1.out_reject};
        if (b1.in_valid && b1.in_ready) begin
          exp_t e;
          e.x0 = b1.in_x0; e.y0 = b1.in_y0; e.x1 = b1.in_x1; e.y1 = b1.in_y1;
          e.c0 = oc(int'(b1.in_x0), int'(b1.in_y0));
          e.c1 = oc(int'(b1.in_x1), int'(b1.in_y1));
          e.acc = ((e.c0 | e.c1) == 4'b0000);
          e.rej = ((e.c0 & e.c1) != 4'b0000);
          exp_q.push_back(e);
        end
        if (b1.cfg_we) begin
          wxmin = int'(b1.cfg_xmin); wxmax = int'(b1.cfg_xmax);
          wymin = int'(b1.cfg_ymin); wymax = int'(b1.cfg_ymax);
        end
      end
    end
  end

  task automatic send(input int x0, input int y0, input int x1, input int y1);
    logic hs;
    b1.in_valid = 1'b1;
    b1.in_x0 = 16'(x0); b1.in_y0 = 16'(y0); b1.in_x1 = 16'(x1); b1.in_y1 = 16'(y1);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      hs = b1.in_ready;
      @(posedge clk); #1;
      if (hs) begin
        b1.in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 64'(1), 64'(0));
    b1.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic model_reset();
    exp_q.delete();
    wxmin = 0; wxmax = 640; wymin = 0; wymax = 480;
    m_acc = 0; m_rej = 0; m_clip = 0; m2_acc = 0; m2_rej = 0; m2_clip = 0;
  endtask

  int k;
  int bp_x[4] = '{10, 700, -20, 320};

  initial begin
    b1.cfg_we = 0; b1.cfg_xmin = 0; b1.cfg_xmax = 0; b1.cfg_ymin = 0; b1.cfg_ymax = 0;
    b1.in_valid = 0; b1.in_x0 = 0; b1.in_y0 = 0; b1.in_x1 = 0; b1.in_y1 = 0;
    b1.out_ready = 1; b1.cnt_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(b1.out_valid), 64'(0));
    chk("rst_in_ready", 64'(b1.in_ready), 64'(1));
    chk("rst_out_data", {b1.out_x0, b1.out_y0, b1.out_x1, b1.out_y1}, 64'(0));
    chk("rst_out_codes", 64'({b1.out_code0, b1.out_code1, b1.out_accept, b1.out_reject}), 64'(0));
    #1 rst = 1'b0;

    // Basic accept with latency check
    send(10, 10, 600, 470);
    @(negedge clk); chk("lat_cycle1_valid", 64'(b1.out_valid), 64'(0));
    @(negedge clk); chk("lat_cycle2_valid", 64'(b1.out_valid), 64'(1));
    chk("t1_codes", 64'({b1.out_code0, b1.out_code1, b1.out_accept, b1.out_reject}), 64'(10'b0000000010));
    drain();
    chk("t1_cnt_accept", 64'(b1.cnt_accept), 64'(1));

    send(-5, 20, -1, 700);
    send(-5, -5, 641, 481);
    send(0, 0, 640, 480);
    send(641, 0, 640, 481);
    drain();
    chk("t2_cnt_accept", 64'(b1.cnt_accept), 64'(2));
    chk("t2_cnt_reject", 64'(b1.cnt_reject), 64'(1));
    chk("t2_cnt_clip", 64'(b1.cnt_clip), 64'(2));

    // Backpressure: out_ready low for 5 cycles while streaming 4 segments
    b1.out_ready = 0;
    k = 0;
    b1.in_valid = 1; b1.in_x0 = 16'(bp_x[0]); b1.in_y0 = 16'(5); b1.in_x1 = 16'(bp_x[0]); b1.in_y1 = 16'(6);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (b1.in_ready) k++;
      @(posedge clk); #1;
      if (k < 4) begin
        b1.in_x0 = 16'(bp_x[k]); b1.in_y0 = 16'(5 + k); b1.in_x1 = 16'(bp_x[k]); b1.in_y1 = 16'(6 + k);
      end
    end
    chk("bp_accepted", 64'(k), 64'(2));
    chk("bp_in_ready", 64'(b1.in_ready), 64'(0));
    b1.in_valid = 0;
    b1.out_ready = 1;
    for (int j = 2; j < 4; j++) send(bp_x[j], 5 + j, bp_x[j], 6 + j);
    drain();

    // Window update coincident with a segment: that segment sees the old window
    b1.cfg_we = 1; b1.cfg_xmin = 100; b1.cfg_xmax = 200; b1.cfg_ymin = 100; b1.cfg_ymax = 200;
    b1.in_valid = 1; b1.in_x0 = 50; b1.in_y0 = 150; b1.in_x1 = 150; b1.in_y1 = 150;
    @(negedge clk); chk("cfg_in_ready", 64'(b1.in_ready), 64'(1));
    @(posedge clk); #1;
    b1.cfg_we = 0; b1.in_valid = 0;
    send(50, 150, 150, 150);
    drain();

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      b1.in_valid = ($urandom_range(0, 9) < 7);
      b1.in_x0 = 16'(int'($urandom_range(0, 900)) - 150);
      b1.in_y0 = 16'(int'($urandom_range(0, 700)) - 110);
      b1.in_x1 = 16'(int'($urandom_range(0, 900)) - 150);
      b1.in_y1 = 16'(int'($urandom_range(0, 700)) - 110);
      b1.out_ready = ($urandom_range(0, 9) < 7);
      b1.cfg_we = ($urandom_range(0, 99) < 3);
      b1.cfg_xmin = 16'(int'($urandom_range(0, 700)) - 100);
      b1.cfg_xmax = 16'(int'($urandom_range(0, 700)) - 100);
      b1.cfg_ymin = 16'(int'($urandom_range(0, 600)) - 100);
      b1.cfg_ymax = 16'(int'($urandom_range(0, 600)) - 100);
      b1.cnt_clr = ($urandom_range(0, 99) < 2);
      @(posedge clk); #1;
    end
    b1.in_valid = 0; b1.cfg_we = 0; b1.cnt_clr = 0; b1.out_ready = 1;
    drain();

    // Saturation on the narrow-counter instance
    b1.cfg_we = 1; b1.cfg_xmin = 0; b1.cfg_xmax = 640; b1.cfg_ymin = 0; b1.cfg_ymax = 480;
    b1.cnt_clr = 1;
    @(posedge clk); #1;
    b1.cfg_we = 0; b1.cnt_clr = 0;
    for (int j = 0; j < 5; j++) send(10 * j, 20, 30, 40 + j);
    drain();
    chk("sat_cnt2_accept", 64'(b2.cnt_accept), 64'(3));
    chk("sat_cnt_accept", 64'(b1.cnt_accept), 64'(5));

    // Reset mid-stream with a full, stalled pipe
    b1.cfg_we = 1; b1.cfg_xmin = 100; b1.cfg_xmax = 200; b1.cfg_ymin = 100; b1.cfg_ymax = 200;
    @(posedge clk); #1;
    b1.cfg_we = 0;
    b1.out_ready = 0;
    send(1, 2, 3, 4);
    send(5, 6, 7, 8);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(b1.out_valid), 64'(0));
    chk("mid_rst_cnts", 64'({b1.cnt_accept, b1.cnt_reject, b1.cnt_clip}), 64'(0));
    chk("mid_rst_cnts2", 64'({b2.cnt_accept, b2.cnt_reject, b2.cnt_clip}), 64'(0));
    chk("mid_rst_in_ready", 64'(b1.in_ready), 64'(1));
    model_reset();
    b1.out_ready = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    send(50, 150, 640, 480);
    send(641, 0, 640, 481);
    drain();
    chk("post_rst_cnt_accept", 64'(b1.cnt_accept), 64'(1));
    chk("post_rst_cnt_clip", 64'(b1.cnt_clip), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
